signed_bcd_conv: RTL and testbench
==================================

Name: signed_bcd_conv

Overview:
Downstream consumer of the 12-bit up/down step counter. It captures the counter value (two's complement) and its overflow flag on a start request. It converts the value to sign plus 4-digit packed BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock. The result drives the board display path; a start/busy/done handshake lets the control logic sample the counter only when the converter is free.

Parameters:
WIDTH, 12, input value width (two's complement); engine iterates WIDTH times
DIGITS, 4, BCD output digits; must satisfy 10^DIGITS > 2^(WIDTH-1) (4 for WIDTH=12)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  conversion request; sampled only in IDLE
value_in  input  WIDTH  counter value to convert, two's complement
ovf_in  input  1  counter overflow flag, captured with value_in
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse: new result valid on bcd/neg/ovf_out
neg  output  1  sign of converted value (1 = negative)
bcd  output  4*DIGITS  packed BCD magnitude, digit 0 in bits [3:0]
ovf_out  output  1  ovf_in as captured at start of the reported conversion

Behaviour:
- Reset (sync, active-high, overrides everything): state=IDLE, busy=0, done=0, neg=0, bcd=0, ovf_out=0, internal shift/iteration registers cleared. Reset mid-conversion aborts it: no done pulse, outputs cleared.
- FSM has two states: IDLE and CONV.
- IDLE: if start=1 at edge E0, then:
  - capture mag = value_in[WIDTH-1] ? (~value_in + 1) mod 2^WIDTH : value_in, treated as unsigned WIDTH bits (so -2048 -> 2048);
  - capture sign = value_in[WIDTH-1] and ovf = ovf_in;
  - clear the BCD scratch register and set iter = WIDTH;
  - go to CONV with busy=1.
  If start=0, stay in IDLE.
- CONV: on each edge E1..E_WIDTH:
  - every scratch digit >= 5 gets +3 (4-bit add, no carry between digits);
  - then {scratch, mag} shifts left one bit;
  - iter decrements.
- On edge E_WIDTH (iter reaches 0):
  - bcd <= final scratch, neg <= sign, ovf_out <= ovf;
  - done <= 1 for exactly one cycle, busy <= 0, state <= IDLE.
- Latency: done is high in the cycle after edge E_WIDTH, i.e. WIDTH (12) clocks after the start-sampling edge. busy is high for exactly WIDTH cycles.
- start while busy=1 is ignored; there is no queueing and value_in is not re-sampled.
- start=1 in the cycle done=1 (state IDLE) is accepted; back-to-back throughput is one result every WIDTH+1 cycles.
- bcd, neg and ovf_out hold the last result until the next completion. They never show intermediate scratch values.
- value_in=0 gives neg=0, bcd=0. Negative zero cannot occur.
- done must never be asserted without a preceding accepted start.

Test Plan:
1. Assert rst for 2 cycles with start=1 -> busy=0, done=0, bcd=0x0000, neg=0, ovf_out=0; no conversion begins during reset.
2. start pulse, value_in=0x4D2 (1234), ovf_in=0 -> busy high 12 cycles; done pulses 12 cycles after the start edge; bcd=0x1234, neg=0, ovf_out=0.
3. value_in=0x800 -> bcd=0x2048, neg=1. value_in=0xFFF -> bcd=0x0001, neg=1. value_in=0x7FF -> bcd=0x2047, neg=0. value_in=0x000 -> bcd=0x0000, neg=0.
4. Start 0x064 (100); at cycle 4 of CONV assert start with value_in=0x3E7 -> second start ignored; done once, bcd=0x0100; no second done.
5. Start 0x00A with ovf_in=1; assert start again with value_in=0x014 in the done cycle -> first done: bcd=0x0010, ovf_out=1; second done exactly 13 cycles after the first: bcd=0x0020, ovf_out=0.
6. Complete a conversion (bcd=0x1234), start another, then assert rst at CONV cycle 5 -> next cycle: busy=0, bcd=0x0000, no done pulse; a new start afterwards converts normally.

Source files
------------

// File: rtl/signed_bcd_conv.sv
// Signed two's-complement to sign + packed BCD converter.
// Sequential double-dabble engine, one input bit per clock, with start/busy/done handshake.
module signed_bcd_conv #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value_in,
    input  logic                  ovf_in,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf_out
);

    localparam int ITER_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t              state, state_next;
    logic                load, finish;
    logic [WIDTH-1:0]    mag, mag_in;
    logic [4*DIGITS-1:0] scratch, scratch_adj, scratch_shift;
    logic [ITER_W-1:0]   iter;
    logic                sign, ovf;

    assign busy   = (state == CONV);
    assign mag_in = value_in[WIDTH-1] ? (~value_in + WIDTH'(1)) : value_in;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                if (iter == ITER_W'(1)) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction per digit (no inter-digit carry), then shift in the next magnitude bit.
    always_comb begin
        scratch_adj = '0;
        for (int d = 0; d < DIGITS; d++) begin
            scratch_adj[4*d +: 4] = (scratch[4*d +: 4] >= 4'd5) ? scratch[4*d +: 4] + 4'd3
                                                                 : scratch[4*d +: 4];
        end
        scratch_shift = {scratch_adj[4*DIGITS-2:0], mag[WIDTH-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag     <= '0;
            scratch <= '0;
            iter    <= '0;
            sign    <= 1'b0;
            ovf     <= 1'b0;
            bcd     <= '0;
            neg     <= 1'b0;
            ovf_out <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                mag     <= mag_in;
                sign    <= value_in[WIDTH-1];
                ovf     <= ovf_in;
                scratch <= '0;
                iter    <= ITER_W'(WIDTH);
            end else if (state == CONV) begin
                scratch <= scratch_shift;
                mag     <= {mag[WIDTH-2:0], 1'b0};
                iter    <= iter - ITER_W'(1);
                // Outputs only ever see the completed scratch value.
                if (finish) begin
                    bcd     <= scratch_shift;
                    neg     <= sign;
                    ovf_out <= ovf;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_signed_bcd_conv.sv
// Self-checking bench for signed_bcd_conv: table-driven conversions plus
// hand-written sequences for ignored start, back-to-back start and mid-conversion reset.
module tb_signed_bcd_conv;

    localparam int WIDTH  = 12;
    localparam int DIGITS = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [WIDTH-1:0]    value_in;
    logic                ovf_in;
    logic                busy;
    logic                done;
    logic                neg;
    logic [4*DIGITS-1:0] bcd;
    logic                ovf_out;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [WIDTH-1:0]    value;
        logic                ovf;
        logic [4*DIGITS-1:0] exp_bcd;
        logic                exp_neg;
    } vec_t;

    vec_t vecs[7];

    signed_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .value_in (value_in),
        .ovf_in   (ovf_in),
        .busy     (busy),
        .done     (done),
        .neg      (neg),
        .bcd      (bcd),
        .ovf_out  (ovf_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at the falling edge right after the start-sampling edge.
    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic start_pulse(input logic [WIDTH-1:0] v, input logic o);
        @(negedge clk);
        start    = 1'b1;
        value_in = v;
        ovf_in   = o;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic run_conv(input string name, input logic [WIDTH-1:0] v, input logic o,
                            input logic [15:0] exp_bcd, input logic exp_neg);
        int edges, busy_cnt;
        start_pulse(v, o);
        wait_done(edges, busy_cnt);
        check({name, " latency"}, edges, 12);
        check({name, " busy_cycles"}, busy_cnt, 12);
        check({name, " bcd"}, bcd, exp_bcd);
        check({name, " neg"}, neg, exp_neg);
        check({name, " ovf_out"}, ovf_out, o);
        @(negedge clk);
        check({name, " done_one_cycle"}, done, 0);
        check({name, " bcd_hold"}, bcd, exp_bcd);
    endtask

    initial begin
        int edges, busy_cnt, done_cnt;

        vecs[0] = '{12'h4D2, 1'b0, 16'h1234, 1'b0};
        vecs[1] = '{12'h800, 1'b0, 16'h2048, 1'b1};
        vecs[2] = '{12'hFFF, 1'b0, 16'h0001, 1'b1};
        vecs[3] = '{12'h7FF, 1'b0, 16'h2047, 1'b0};
        vecs[4] = '{12'h000, 1'b0, 16'h0000, 1'b0};
        vecs[5] = '{12'hC18, 1'b1, 16'h1000, 1'b1};
        vecs[6] = '{12'h3E7, 1'b1, 16'h0999, 1'b0};

        // Reset held for two cycles with start asserted.
        rst      = 1'b1;
        start    = 1'b1;
        value_in = 12'h4D2;
        ovf_in   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst busy", busy, 0);
            check("rst done", done, 0);
            check("rst bcd", bcd, 0);
            check("rst neg", neg, 0);
            check("rst ovf_out", ovf_out, 0);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("post_rst busy", busy, 0);

        for (int i = 0; i < 7; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].value, vecs[i].ovf,
                     vecs[i].exp_bcd, vecs[i].exp_neg);
        end

        // Start during CONV cycle 4 must be ignored.
        start_pulse(12'h064, 1'b0);
        repeat (3) @(negedge clk);
        start    = 1'b1;
        value_in = 12'h3E7;
        @(negedge clk);
        start    = 1'b0;
        wait_done(edges, busy_cnt);
        check("ignore latency", edges + 4, 12);
        check("ignore bcd", bcd, 16'h0100);
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("ignore extra_done", done_cnt, 0);
        check("ignore busy_idle", busy, 0);

        // Start accepted in the done cycle.
        start_pulse(12'h00A, 1'b1);
        wait_done(edges, busy_cnt);
        check("b2b first bcd", bcd, 16'h0010);
        check("b2b first ovf", ovf_out, 1);
        start    = 1'b1;
        value_in = 12'h014;
        ovf_in   = 1'b0;
        @(negedge clk);
        start    = 1'b0;
        check("b2b busy_restart", busy, 1);
        wait_done(edges, busy_cnt);
        check("b2b spacing", edges + 1, 13);
        check("b2b second bcd", bcd, 16'h0020);
        check("b2b second ovf", ovf_out, 0);

        // Reset during CONV cycle 5 aborts the conversion.
        run_conv("pre_abort", 12'h4D2, 1'b0, 16'h1234, 1'b0);
        start_pulse(12'h4D2, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", busy, 0);
        check("abort bcd", bcd, 0);
        check("abort neg", neg, 0);
        check("abort ovf_out", ovf_out, 0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("abort no_done", done_cnt, 0);
        run_conv("post_abort", 12'h3E7, 1'b0, 16'h0999, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
